fpu_result_buffer: RTL and testbench
====================================

FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

Interface
REQ-001 Parameter DEPTH, 4, number of result entries; power of two, 2..16.
REQ-002 Parameter DATA_W, 32, result width.
REQ-003 Parameter TAG_W, 1, tag width.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset; asynchronous, active-low.
REQ-006 flush_i  in  1  discard all buffered entries.
REQ-007 in_valid_i  in  1  upstream FPU result valid (fpnew out_valid_o).
REQ-008 in_ready_o  out  1  buffer can accept (drives fpnew out_ready_i).
REQ-009 result_i  in  DATA_W  FPU result.
REQ-010 status_i  in  5  FPU status flags {NV,DZ,OF,UF,NX}.
REQ-011 tag_i  in  TAG_W  FPU tag.
REQ-012 out_valid_o  out  1  head entry valid.
REQ-013 out_ready_i  in  1  consumer accepts head entry.
REQ-014 result_o / status_o / tag_o  out  DATA_W / 5 / TAG_W  head entry fields.
REQ-015 fflags_o  out  5  sticky OR of all accepted status flags.
REQ-016 clr_fflags_i  in  1  clear fflags_o.
REQ-017 count_o  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 Push SHALL occur when in_valid_i and in_ready_o are both high; pop when out_valid_o and out_ready_i are both high.
REQ-019 in_ready_o SHALL equal (count_o != DEPTH), with no combinational dependence on out_ready_i or in_valid_i.
REQ-020 out_valid_o SHALL equal (count_o != 0); result_o/status_o/tag_o SHALL show the oldest entry (first-word fall-through from storage, no input bypass).
REQ-021 Latency: a pushed entry SHALL appear at the outputs the cycle after the push, even when the buffer is empty.
REQ-022 Order SHALL be strict FIFO; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-024 When full, push is blocked; a pop in that cycle SHALL lower count to DEPTH-1 and raise in_ready_o next cycle.
REQ-025 While out_valid_o is high and out_ready_i is low, head fields SHALL remain stable.
REQ-026 fflags_o SHALL OR in status_i of each accepted push on the push edge.
REQ-027 clr_fflags_i together with a push SHALL leave fflags_o equal to that push's status_i; clr_fflags_i alone SHALL zero fflags_o.
REQ-028 flush_i SHALL set count and both pointers to 0 on the next edge, with priority over push/pop in the same cycle (the push is dropped); fflags_o SHALL be unaffected.
REQ-029 Storage contents SHALL NOT be reset; only pointers, count, and fflags SHALL be reset.

Reset
REQ-030 On rst_ni low, asynchronously: count_o=0, out_valid_o=0, in_ready_o=1, fflags_o=0, pointers=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; after deassertion, the first push SHALL be the first entry read.
REQ-032 Result fields are don't-care while out_valid_o=0.

Structure
REQ-033 The status flag struct SHALL be fpnew_pkg::status_t; the shared lab package SHALL hold the default DEPTH constant.
REQ-034 The module SHALL be a single flat module with no sub-module; the storage array, pointer logic, and occupancy counter SHALL be local.
REQ-035 The module SHALL instantiate downstream of fpnew_top, with in_ready_o driving out_ready_i.

Verification
REQ-036 Reset, then push 0x3F800000/status 0/tag 1 -> next cycle: out_valid_o=1, result_o=0x3F800000, count_o=1.
REQ-037 Push 5 results with out_ready_i=0, DEPTH=4 -> in_ready_o=0 after the 4th push; the 5th is held upstream; drain order is 1..4.
REQ-038 Full buffer, pop and push request in the same cycle -> the push is refused; count becomes 3; in_ready_o=1 next cycle.
REQ-039 Push status 5'b00001 then 5'b10000 -> fflags_o=5'b10001; clr_fflags_i with a push of status 5'b00100 -> fflags_o=5'b00100.
REQ-040 count=3 and flush_i with a simultaneous push -> count_o=0 and out_valid_o=0 next cycle; fflags_o is unchanged.
REQ-041 Assert rst_ni low asynchronously mid-burst with count=2 -> outputs return to reset values immediately; the next push/pop sequence is correct.

Source files
------------

// File: rtl/fpu_result_buffer_pkg.sv
// Shared types and defaults for the FPU result buffer: FPU status flag layout
// and the default entry count.
package fpu_result_buffer_pkg;

   localparam int unsigned DEFAULT_DEPTH = 4;
   localparam int unsigned STATUS_W      = 5;

   // Same bit order as fpnew_pkg::status_t: {NV,DZ,OF,UF,NX}, MSB first
   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

   function automatic status_t status_or(input status_t a, input status_t b);
      return status_t'(a | b);
   endfunction

endpackage

// File: rtl/fpu_result_buffer.sv
// First-word fall-through result FIFO placed after the FPU.
// It also accumulates sticky exception flags from every accepted result.
module fpu_result_buffer
   import fpu_result_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 1,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] result_i,
   input  status_t           status_i,
   input  logic [TAG_W-1:0]  tag_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] result_o,
   output status_t           status_o,
   output logic [TAG_W-1:0]  tag_o,
   output status_t           fflags_o,
   input  logic              clr_fflags_i,
   output logic [CW-1:0]     count_o
);

   logic [DATA_W-1:0] res_q  [DEPTH];
   status_t           stat_q [DEPTH];
   logic [TAG_W-1:0]  tag_q  [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   status_t       fflags_q, fflags_d;

   logic push, pop, push_en;
   status_t push_status;

   // Handshakes depend only on registered occupancy, never on the peer's strobe
   assign in_ready_o  = (count_q != CW'(DEPTH));
   assign out_valid_o = (count_q != '0);

   assign push    = in_valid_i & in_ready_o;
   assign pop     = out_valid_o & out_ready_i;
   assign push_en = push & ~flush_i;

   assign push_status = push_en ? status_i : status_t'('0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // A clear coinciding with a push keeps only that push's flags
   always_comb begin
      if (clr_fflags_i) fflags_d = push_status;
      else              fflags_d = status_or(fflags_q, push_status);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fflags_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         fflags_q <= fflags_d;
      end
   end

   // Storage is deliberately left out of reset
   always_ff @(posedge clk_i) begin
      if (push_en) begin
         res_q[wr_ptr_q]  <= result_i;
         stat_q[wr_ptr_q] <= status_i;
         tag_q[wr_ptr_q]  <= tag_i;
      end
   end

   assign result_o = res_q[rd_ptr_q];
   assign status_o = stat_q[rd_ptr_q];
   assign tag_o    = tag_q[rd_ptr_q];
   assign fflags_o = fflags_q;
   assign count_o  = count_q;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Self-checking bench for fpu_result_buffer: directed table, hand sequences
// for full/drain and async reset, then random traffic against a queue model.
module tb_fpu_result_buffer;
   import fpu_result_buffer_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] result_i = '0;
   logic [4:0]  status_i = '0;
   logic [0:0]  tag_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] result_o;
   status_t     status_o;
   logic [0:0]  tag_o;
   status_t     fflags_o;
   logic        clr_fflags_i = 1'b0;
   logic [2:0]  count_o;

   fpu_result_buffer #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(1)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .result_i(result_i), .status_i(status_i), .tag_i(tag_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
      .fflags_o(fflags_o), .clr_fflags_i(clr_fflags_i), .count_o(count_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid_i = 1'b0; out_ready_i = 1'b0; clr_fflags_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cnt"}, 32'(count_o), 32'd0);
      chk({tag, "_vld"}, 32'(out_valid_o), 32'd0);
      chk({tag, "_rdy"}, 32'(in_ready_o), 32'd1);
      chk({tag, "_ff"},  32'(fflags_o), 32'd0);
   endtask

   typedef struct {
      logic        push;
      logic [31:0] data;
      logic [4:0]  st;
      logic        tag;
      logic        pop;
      logic        clr;
      logic        flush;
      logic [2:0]  e_cnt;
      logic        e_vld;
      logic        e_rdy;
      logic [31:0] e_head;
      logic [4:0]  e_ff;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  st;
      logic        tag;
   } ent_t;

   vec_t vec [10];
   ent_t q [$];
   logic [4:0] mff;

   initial begin
      // state after each edge, starting from an empty buffer
      vec[0] = '{1'b1, 32'h3F800000, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h3F800000, 5'h00};
      vec[1] = '{1'b1, 32'h11, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h3F800000, 5'h01};
      vec[2] = '{1'b1, 32'h22, 5'h10, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h11, 5'h11};
      vec[3] = '{1'b1, 32'h33, 5'h04, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 32'h11, 5'h04};
      vec[4] = '{1'b1, 32'h44, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h11, 5'h04};
      vec[5] = '{1'b1, 32'h55, 5'h08, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h22, 5'h04};
      vec[6] = '{1'b1, 32'h66, 5'h02, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 32'h0,  5'h04};
      vec[7] = '{1'b0, 32'h0,  5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,  5'h00};
      vec[8] = '{1'b1, 32'h77, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h77, 5'h00};
      vec[9] = '{1'b0, 32'h0,  5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,  5'h00};

      #2;
      check_reset_vals("rst");
      #10 rst_ni = 1'b1;
      step();
      check_reset_vals("post_rst");

      // directed table
      for (int i = 0; i < 10; i++) begin
         in_valid_i = vec[i].push; result_i = vec[i].data; status_i = vec[i].st;
         tag_i = vec[i].tag; out_ready_i = vec[i].pop; clr_fflags_i = vec[i].clr;
         flush_i = vec[i].flush;
         step();
         chk($sformatf("v%0d_cnt", i), 32'(count_o), 32'(vec[i].e_cnt));
         chk($sformatf("v%0d_vld", i), 32'(out_valid_o), 32'(vec[i].e_vld));
         chk($sformatf("v%0d_rdy", i), 32'(in_ready_o), 32'(vec[i].e_rdy));
         chk($sformatf("v%0d_ff", i), 32'(fflags_o), 32'(vec[i].e_ff));
         if (vec[i].e_vld) chk($sformatf("v%0d_head", i), result_o, vec[i].e_head);
         if (i == 0) chk("v0_tag", 32'(tag_o), 32'd1);
      end
      idle();

      // fill to full with the consumer stalled; the fifth result waits upstream
      for (int i = 1; i <= 4; i++) begin
         in_valid_i = 1'b1; result_i = 32'(i); status_i = 5'h00;
         step();
         chk($sformatf("fill%0d_rdy", i), 32'(in_ready_o), (i == 4) ? 32'd0 : 32'd1);
      end
      result_i = 32'd5;
      step();
      step();
      chk("held_cnt", 32'(count_o), 32'd4);
      chk("held_head", result_o, 32'd1);
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("drain%0d", i), result_o, 32'(i));
         step();
      end
      chk("drain_empty", 32'(out_valid_o), 32'd0);
      idle();

      // async reset mid-burst at count 2
      in_valid_i = 1'b1; result_i = 32'hA1; step();
      result_i = 32'hA2; step();
      idle();
      chk("pre_ar_cnt", 32'(count_o), 32'd2);
      #2 rst_ni = 1'b0;
      #1 check_reset_vals("arst");
      #2 rst_ni = 1'b1;
      in_valid_i = 1'b1; result_i = 32'hB1; step();
      chk("ar_first", result_o, 32'hB1);
      result_i = 32'hB2; out_ready_i = 1'b1; step();
      chk("ar_second", result_o, 32'hB2);
      chk("ar_cnt", 32'(count_o), 32'd1);
      idle();

      // sync model to DUT: empty buffer, cleared flags
      flush_i = 1'b1; clr_fflags_i = 1'b1; step();
      idle();
      q.delete();
      mff = '0;

      for (int c = 0; c < 400; c++) begin
         bit push, pop, fl, cl;
         ent_t e;
         e.data = $urandom; e.st = 5'($urandom_range(0, 31)); e.tag = 1'($urandom_range(0, 1));
         in_valid_i = ($urandom_range(0, 3) != 0);
         out_ready_i = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 31) == 0);
         cl = ($urandom_range(0, 15) == 0);
         flush_i = fl; clr_fflags_i = cl;
         result_i = e.data; status_i = e.st; tag_i = e.tag;
         push = in_valid_i && (q.size() < DEPTH);
         pop = out_ready_i && (q.size() > 0);
         step();
         if (fl) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
         end
         if (cl) mff = (push && !fl) ? e.st : 5'h00;
         else if (push && !fl) mff = mff | e.st;
         chk("r_cnt", 32'(count_o), 32'(q.size()));
         chk("r_rdy", 32'(in_ready_o), 32'(q.size() < DEPTH));
         chk("r_ff", 32'(fflags_o), 32'(mff));
         if (q.size() > 0) begin
            chk("r_head", result_o, q[0].data);
            chk("r_st", 32'(status_o), 32'(q[0].st));
            chk("r_tag", 32'(tag_o), 32'(q[0].tag));
         end else chk("r_vld", 32'(out_valid_o), 32'd0);
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
